// File: rtl/tdo_capture.sv
// tdo_capture: packs the sampled TDO stream LSB first into D_WIDTH-bit
// words and writes them to the vector_2 RAM port from a programmed base.
//
// Ports:
//   clk, reset_n             clock, async active-low reset
//   start, abort             one-cycle control pulses
//   cap_base, cap_bits       capture base address and bit count
//   tdo, tdo_valid           sampled TDO bit and its strobe
//   vector_2_addr/we/wr_data registered RAM write port
//   busy, done               capture in progress, completion pulse
//   bits_captured            bits accepted since last accepted start
//   overrun                  sticky: strobe seen outside a capture

module tdo_capture #(
    parameter int D_WIDTH = 8,
    parameter int A_WIDTH = 12
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               abort,
    input  logic [A_WIDTH-1:0] cap_base,
    input  logic [15:0]        cap_bits,
    input  logic               tdo,
    input  logic               tdo_valid,
    output logic [A_WIDTH-1:0] vector_2_addr,
    output logic               vector_2_we,
    output logic [D_WIDTH-1:0] vector_2_wr_data,
    output logic               busy,
    output logic               done,
    output logic [15:0]        bits_captured,
    output logic               overrun
);

    localparam int IW = (D_WIDTH > 1) ? $clog2(D_WIDTH) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(D_WIDTH - 1);

    localparam logic ST_IDLE    = 1'b0;
    localparam logic ST_CAPTURE = 1'b1;

    logic               state;
    logic [A_WIDTH-1:0] cur_addr;
    logic [15:0]        len;
    logic [IW-1:0]      idx;
    logic [D_WIDTH-1:0] shreg;

    logic               accept_start;
    logic               take_bit;
    logic               idx_last;
    logic               last_bit;
    logic               word_done;
    logic [IW-1:0]      idx_next;
    logic [D_WIDTH-1:0] next_word;

    always_comb begin
        // abort outranks both a start and a strobe in the same cycle
        accept_start = (state == ST_IDLE) && start && !abort;
        take_bit     = (state == ST_CAPTURE) && tdo_valid && !abort;
        idx_last     = (idx == IDX_LAST);
        last_bit     = ((bits_captured + 16'd1) == len);
        word_done    = take_bit && (idx_last || last_bit);
        idx_next     = idx_last ? '0 : idx + 1'b1;
        // shreg is cleared after every write, so the unfilled upper
        // bits of a short final word are already zero
        next_word      = shreg;
        next_word[idx] = tdo;
    end

    assign busy = (state == ST_CAPTURE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= ST_IDLE;
            cur_addr         <= '0;
            len              <= '0;
            idx              <= '0;
            shreg            <= '0;
            bits_captured    <= '0;
            overrun          <= 1'b0;
            done             <= 1'b0;
            vector_2_we      <= 1'b0;
            vector_2_addr    <= '0;
            vector_2_wr_data <= '0;
        end else begin
            done        <= 1'b0;
            vector_2_we <= 1'b0;

            if (state == ST_IDLE) begin
                if (accept_start) begin
                    cur_addr      <= cap_base;
                    len           <= cap_bits;
                    bits_captured <= '0;
                    idx           <= '0;
                    shreg         <= '0;
                    // the clear beats a strobe arriving with start
                    overrun       <= 1'b0;
                    if (cap_bits == 16'd0) begin
                        done <= 1'b1;
                    end else begin
                        state <= ST_CAPTURE;
                    end
                end else if (tdo_valid) begin
                    overrun <= 1'b1;
                end
            end else begin
                if (abort) begin
                    state <= ST_IDLE;
                end else if (take_bit) begin
                    bits_captured <= bits_captured + 16'd1;
                    idx           <= idx_next;
                    if (word_done) begin
                        vector_2_we      <= 1'b1;
                        vector_2_addr    <= cur_addr;
                        vector_2_wr_data <= next_word;
                        cur_addr         <= cur_addr + 1'b1;
                        shreg            <= '0;
                    end else begin
                        shreg <= next_word;
                    end
                    if (last_bit) begin
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_tdo_capture.sv
// tb_tdo_capture: directed bench for tdo_capture with a write scoreboard.
// Expected RAM writes are queued as stimulus is driven, popped on writes.

module tb_tdo_capture;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic [11:0] cap_base;
    logic [15:0] cap_bits;
    logic        tdo;
    logic        tdo_valid;
    logic [11:0] vector_2_addr;
    logic        vector_2_we;
    logic [7:0]  vector_2_wr_data;
    logic        busy;
    logic        done;
    logic [15:0] bits_captured;
    logic        overrun;

    typedef struct {
        logic [11:0] addr;
        logic [7:0]  data;
        logic        last;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   wr_cnt = 0;
    int   done_cnt = 0;

    tdo_capture #(.D_WIDTH(8), .A_WIDTH(12)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .abort            (abort),
        .cap_base         (cap_base),
        .cap_bits         (cap_bits),
        .tdo              (tdo),
        .tdo_valid        (tdo_valid),
        .vector_2_addr    (vector_2_addr),
        .vector_2_we      (vector_2_we),
        .vector_2_wr_data (vector_2_wr_data),
        .busy             (busy),
        .done             (done),
        .bits_captured    (bits_captured),
        .overrun          (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (done === 1'b1) done_cnt++;
            if (vector_2_we === 1'b1) begin
                wr_cnt++;
                chk("sb_has_entry", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("wr_addr", 32'(vector_2_addr), 32'(e.addr));
                    chk("wr_data", 32'(vector_2_wr_data), 32'(e.data));
                    chk("wr_done", 32'(done), 32'(e.last));
                end
            end
        end
    end

    task automatic push(input logic [11:0] a, input logic [7:0] d,
                        input logic l);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.last = l;
        sb.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [11:0] b, input logic [15:0] n);
        cap_base = b;
        cap_bits = n;
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic strobe(input logic b);
        tdo = b;
        tdo_valid = 1'b1;
        cyc();
        tdo_valid = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_we"}, 32'(vector_2_we), 0);
        chk({tag, "_addr"}, 32'(vector_2_addr), 0);
        chk({tag, "_data"}, 32'(vector_2_wr_data), 0);
        chk({tag, "_bits"}, 32'(bits_captured), 0);
        chk({tag, "_ovr"}, 32'(overrun), 0);
    endtask

    initial begin
        int w0;
        int d0;
        logic [7:0] pat;

        reset_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        cap_base = '0;
        cap_bits = '0;
        tdo = 1'b0;
        tdo_valid = 1'b0;
        cyc();
        cyc();
        chk_all_zero("reset");
        reset_n = 1'b1;
        cyc();

        // single byte: 1,0,1,1,0,0,1,0 -> 0x4D
        push(12'h010, 8'h4D, 1'b1);
        do_start(12'h010, 16'd8);
        chk("sb1_busy_on", 32'(busy), 1);
        pat = 8'h4D;
        for (int i = 0; i < 8; i++) strobe(pat[i]);
        chk("sb1_we", 32'(vector_2_we), 1);
        chk("sb1_done", 32'(done), 1);
        chk("sb1_busy_off", 32'(busy), 0);
        chk("sb1_bits", 32'(bits_captured), 8);
        cyc();
        chk("sb1_done_clr", 32'(done), 0);

        // partial tail, strobes every other cycle
        push(12'h010, 8'hFF, 1'b0);
        push(12'h011, 8'h07, 1'b1);
        do_start(12'h010, 16'd11);
        for (int i = 0; i < 11; i++) begin
            strobe(1'b1);
            cyc();
        end
        chk("tail_bits", 32'(bits_captured), 11);
        chk("tail_busy", 32'(busy), 0);

        // address wrap, bits 0,1 alternating
        push(12'hFFF, 8'hAA, 1'b0);
        push(12'h000, 8'hAA, 1'b1);
        do_start(12'hFFF, 16'd16);
        for (int i = 0; i < 16; i++) strobe(1'(i % 2));
        cyc();
        chk("wrap_bits", 32'(bits_captured), 16);

        // zero length
        w0 = wr_cnt;
        d0 = done_cnt;
        do_start(12'h100, 16'd0);
        chk("zero_done", 32'(done), 1);
        chk("zero_busy", 32'(busy), 0);
        cyc();
        chk("zero_done_clr", 32'(done), 0);
        chk("zero_busy2", 32'(busy), 0);
        cyc();
        chk("zero_no_wr", 32'(wr_cnt - w0), 0);
        chk("zero_one_done", 32'(done_cnt - d0), 1);

        // abort after 5 strobes
        w0 = wr_cnt;
        d0 = done_cnt;
        do_start(12'h020, 16'd8);
        for (int i = 0; i < 5; i++) strobe(1'b1);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_bits", 32'(bits_captured), 5);
        cyc();
        cyc();
        chk("abort_no_wr", 32'(wr_cnt - w0), 0);
        chk("abort_no_done", 32'(done_cnt - d0), 0);
        push(12'h020, 8'h3C, 1'b1);
        do_start(12'h020, 16'd8);
        pat = 8'h3C;
        for (int i = 0; i < 8; i++) strobe(pat[i]);
        chk("post_abort_bits", 32'(bits_captured), 8);
        cyc();

        // abort together with the final strobe
        w0 = wr_cnt;
        d0 = done_cnt;
        do_start(12'h050, 16'd2);
        strobe(1'b1);
        tdo = 1'b1;
        tdo_valid = 1'b1;
        abort = 1'b1;
        cyc();
        tdo_valid = 1'b0;
        abort = 1'b0;
        chk("abfin_bits", 32'(bits_captured), 1);
        chk("abfin_busy", 32'(busy), 0);
        cyc();
        cyc();
        chk("abfin_no_wr", 32'(wr_cnt - w0), 0);
        chk("abfin_no_done", 32'(done_cnt - d0), 0);

        // overrun after completion
        chk("ovr_pre", 32'(overrun), 0);
        w0 = wr_cnt;
        strobe(1'b1);
        chk("ovr_set", 32'(overrun), 1);
        cyc();
        chk("ovr_no_wr", 32'(wr_cnt - w0), 0);
        chk("ovr_sticky", 32'(overrun), 1);

        // start with a strobe in the same cycle: bit dropped
        push(12'h030, 8'h09, 1'b1);
        cap_base = 12'h030;
        cap_bits = 16'd4;
        start = 1'b1;
        tdo = 1'b1;
        tdo_valid = 1'b1;
        cyc();
        start = 1'b0;
        tdo_valid = 1'b0;
        chk("coll_ovr", 32'(overrun), 0);
        chk("coll_bits", 32'(bits_captured), 0);
        chk("coll_busy", 32'(busy), 1);
        pat = 8'h09;
        for (int i = 0; i < 4; i++) strobe(pat[i]);
        chk("coll_bits_end", 32'(bits_captured), 4);
        cyc();

        // async reset mid-capture
        w0 = wr_cnt;
        do_start(12'h040, 16'd8);
        for (int i = 0; i < 3; i++) strobe(1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        cyc();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) strobe(1'b1);
        cyc();
        chk("midrst_no_wr", 32'(wr_cnt - w0), 0);
        chk("midrst_busy", 32'(busy), 0);

        cyc();
        chk("sb_drained", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
